// File: rtl/password_lock_if.sv
// Keypad-side bus of password_lock: conditioned key strobes in, lock status out.
interface password_lock_if #(
    parameter int unsigned N         = 4,
    parameter int unsigned DIGITS    = 4,
    parameter int unsigned MAX_TRIES = 3
);
    localparam int unsigned DCW = $clog2(DIGITS + 1);
    localparam int unsigned FCW = $clog2(MAX_TRIES + 1);

    logic           key_valid;
    logic [N-1:0]   key;
    logic           mode;
    logic           clear;
    logic           unlock;
    logic           err;
    logic           locked;
    logic           prog_done;
    logic [DCW-1:0] digit_cnt;
    logic [FCW-1:0] fail_cnt;

    // Key-conditioning side: drives keys, observes status.
    modport master (
        output key_valid, key, mode, clear,
        input  unlock, err, locked, prog_done, digit_cnt, fail_cnt
    );

    // Lock side: consumes keys, drives status.
    modport slave (
        input  key_valid, key, mode, clear,
        output unlock, err, locked, prog_done, digit_cnt, fail_cnt
    );
endinterface

// File: rtl/password_lock.sv
// Multi-digit keypad password lock with retry counter, timed lockout and
// reprogramming while unlocked.
// Optional feature macro: ENTRY_TIMEOUT_EN -- discards a partial entry (ENTRY or
// PROG) after TIMEOUT idle cycles. Without it a partial entry persists.
module password_lock #(
    parameter int unsigned             N           = 4,
    parameter int unsigned             DIGITS      = 4,
    parameter logic [DIGITS*N-1:0]     DEFAULT_PWD = 16'h1A2B,
    parameter int unsigned             MAX_TRIES   = 3,
    parameter int unsigned             LOCK_CYCLES = 20,
    parameter int unsigned             TIMEOUT     = 16
) (
    input  logic              clk,
    input  logic              rst,
    password_lock_if.slave    bus
);

    localparam int unsigned BW  = DIGITS * N;
    localparam int unsigned DCW = $clog2(DIGITS + 1);
    localparam int unsigned FCW = $clog2(MAX_TRIES + 1);
    localparam int unsigned LCW = $clog2(LOCK_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENTRY,
        S_CHECK,
        S_OPEN,
        S_PROG,
        S_LOCKOUT
    } state_t;

    // Degenerate configurations are rejected at elaboration.
    if (DIGITS == 0 || MAX_TRIES == 0 || LOCK_CYCLES == 0 || TIMEOUT == 0) begin : g_bad_cfg
        $error("password_lock: DIGITS, MAX_TRIES, LOCK_CYCLES and TIMEOUT must be >= 1");
    end

    state_t          state;
    logic [BW-1:0]   entry_buf;
    logic [BW-1:0]   stored;
    logic [LCW-1:0]  lock_cnt;

    logic [BW-1:0]   shifted_c;
    logic [DCW-1:0]  digit_inc_c;
    logic [FCW-1:0]  fail_inc_c;
    logic            last_digit_c;
    logic            idle_expired_c;

    // Entry buffer with the new key shifted in at the LS digit.
    assign shifted_c    = (entry_buf << N) | BW'(bus.key);
    // Saturating counter increments.
    assign digit_inc_c  = (bus.digit_cnt == DCW'(DIGITS)) ? bus.digit_cnt
                                                          : bus.digit_cnt + DCW'(1);
    assign fail_inc_c   = (bus.fail_cnt == FCW'(MAX_TRIES)) ? bus.fail_cnt
                                                            : bus.fail_cnt + FCW'(1);
    // The key being accepted now completes the code.
    assign last_digit_c = (bus.digit_cnt == DCW'(DIGITS - 1));

`ifdef ENTRY_TIMEOUT_EN
    localparam int unsigned ICW = $clog2(TIMEOUT + 1);
    logic [ICW-1:0] idle_cnt;

    assign idle_expired_c = (idle_cnt == ICW'(TIMEOUT - 1));

    // Idle counter: runs only while a partial entry is open, restarts on each key.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idle_cnt <= '0;
        end else if ((state == S_ENTRY || state == S_PROG) && !bus.key_valid) begin
            idle_cnt <= idle_cnt + ICW'(1);
        end else begin
            idle_cnt <= '0;
        end
    end
`else
    assign idle_expired_c = 1'b0;
`endif

    // Lock FSM with registered indicators, counters, entry buffer and stored code.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_IDLE;
            entry_buf     <= '0;
            stored        <= DEFAULT_PWD;
            lock_cnt      <= '0;
            bus.unlock    <= 1'b0;
            bus.err       <= 1'b0;
            bus.locked    <= 1'b0;
            bus.prog_done <= 1'b0;
            bus.digit_cnt <= '0;
            bus.fail_cnt  <= '0;
        end else begin
            bus.err       <= 1'b0;
            bus.prog_done <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (bus.key_valid && !bus.clear) begin
                        entry_buf     <= shifted_c;
                        bus.digit_cnt <= digit_inc_c;
                        state         <= last_digit_c ? S_CHECK : S_ENTRY;
                    end
                end

                S_ENTRY: begin
                    if (bus.clear) begin
                        entry_buf     <= '0;
                        bus.digit_cnt <= '0;
                        state         <= S_IDLE;
                    end else if (bus.key_valid) begin
                        entry_buf     <= shifted_c;
                        bus.digit_cnt <= digit_inc_c;
                        if (last_digit_c) begin
                            state <= S_CHECK;
                        end
                    end else if (idle_expired_c) begin
                        entry_buf     <= '0;
                        bus.digit_cnt <= '0;
                        state         <= S_IDLE;
                    end
                end

                S_CHECK: begin
                    entry_buf     <= '0;
                    bus.digit_cnt <= '0;
                    if (entry_buf == stored) begin
                        bus.unlock   <= 1'b1;
                        bus.fail_cnt <= '0;
                        state        <= S_OPEN;
                    end else begin
                        bus.err      <= 1'b1;
                        bus.fail_cnt <= fail_inc_c;
                        if (fail_inc_c == FCW'(MAX_TRIES)) begin
                            bus.locked <= 1'b1;
                            lock_cnt   <= LCW'(LOCK_CYCLES - 1);
                            state      <= S_LOCKOUT;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end

                S_OPEN: begin
                    if (bus.clear) begin
                        bus.unlock <= 1'b0;
                        state      <= S_IDLE;
                    end else if (bus.key_valid && !bus.mode) begin
                        bus.unlock <= 1'b0;
                        if (last_digit_c) begin
                            // Single-digit code: first program key is also the last.
                            stored        <= shifted_c;
                            bus.prog_done <= 1'b1;
                            state         <= S_IDLE;
                        end else begin
                            entry_buf     <= shifted_c;
                            bus.digit_cnt <= digit_inc_c;
                            state         <= S_PROG;
                        end
                    end
                end

                S_PROG: begin
                    if (bus.clear || bus.mode) begin
                        entry_buf     <= '0;
                        bus.digit_cnt <= '0;
                        bus.unlock    <= 1'b1;
                        state         <= S_OPEN;
                    end else if (bus.key_valid) begin
                        if (last_digit_c) begin
                            stored        <= shifted_c;
                            bus.prog_done <= 1'b1;
                            entry_buf     <= '0;
                            bus.digit_cnt <= '0;
                            state         <= S_IDLE;
                        end else begin
                            entry_buf     <= shifted_c;
                            bus.digit_cnt <= digit_inc_c;
                        end
                    end else if (idle_expired_c) begin
                        entry_buf     <= '0;
                        bus.digit_cnt <= '0;
                        bus.unlock    <= 1'b1;
                        state         <= S_OPEN;
                    end
                end

                S_LOCKOUT: begin
                    // Keys and clear are deliberately ignored until the timer expires.
                    if (lock_cnt == '0) begin
                        bus.locked   <= 1'b0;
                        bus.fail_cnt <= '0;
                        state        <= S_IDLE;
                    end else begin
                        lock_cnt <= lock_cnt - LCW'(1);
                    end
                end

                default: begin
                    entry_buf     <= '0;
                    bus.digit_cnt <= '0;
                    bus.unlock    <= 1'b0;
                    bus.locked    <= 1'b0;
                    state         <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_password_lock.sv
// Directed testbench for password_lock (N=4, DIGITS=4, default code 1A2B).
module tb_password_lock;

    localparam int unsigned N           = 4;
    localparam int unsigned DIGITS      = 4;
    localparam int unsigned MAX_TRIES   = 3;
    localparam int unsigned LOCK_CYCLES = 20;
    localparam int unsigned TIMEOUT     = 16;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    password_lock_if #(.N(N), .DIGITS(DIGITS), .MAX_TRIES(MAX_TRIES)) bus ();

    password_lock #(
        .N           (N),
        .DIGITS      (DIGITS),
        .DEFAULT_PWD (16'h1A2B),
        .MAX_TRIES   (MAX_TRIES),
        .LOCK_CYCLES (LOCK_CYCLES),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison point.
    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Compare all six outputs against hand-computed values.
    task automatic expect_out(input string tag, input int u, input int e, input int l,
                              input int p, input int d, input int f);
        chk({tag, ".unlock"},    int'(bus.unlock),    u);
        chk({tag, ".err"},       int'(bus.err),       e);
        chk({tag, ".locked"},    int'(bus.locked),    l);
        chk({tag, ".prog_done"}, int'(bus.prog_done), p);
        chk({tag, ".digit_cnt"}, int'(bus.digit_cnt), d);
        chk({tag, ".fail_cnt"},  int'(bus.fail_cnt),  f);
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic key_in(input logic [3:0] k);
        bus.key       = k;
        bus.key_valid = 1'b1;
        tick();
        bus.key_valid = 1'b0;
    endtask

    task automatic enter_code(input logic [15:0] code);
        for (int i = 0; i < 4; i++) begin
            key_in(code[15-4*i -: 4]);
        end
    endtask

    task automatic pulse_clear();
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $fatal(1, "FAIL watchdog: simulation time limit reached");
    end

    initial begin
        vectors       = 0;
        miscompares   = 0;
        rst           = 1'b0;
        bus.key_valid = 1'b0;
        bus.key       = '0;
        bus.mode      = 1'b1;
        bus.clear     = 1'b0;
        #12;
        expect_out("reset", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Correct default code unlocks two edges after the last key.
        key_in(4'h1); key_in(4'hA); key_in(4'h2);
        expect_out("t1_partial", 0, 0, 0, 0, 3, 0);
        key_in(4'hB);
        expect_out("t1_check", 0, 0, 0, 0, 4, 0);
        tick();
        expect_out("t1_open", 1, 0, 0, 0, 0, 0);
        pulse_clear();
        expect_out("t1_relock", 0, 0, 0, 0, 0, 0);

        // Single mismatch, then correct code.
        enter_code(16'h1A2C);
        tick();
        expect_out("t2_err", 0, 1, 0, 0, 0, 1);
        tick();
        expect_out("t2_err_gone", 0, 0, 0, 0, 0, 1);
        enter_code(16'h1A2B);
        tick();
        expect_out("t2_open", 1, 0, 0, 0, 0, 0);
        pulse_clear();

        // Three mismatches -> lockout for exactly LOCK_CYCLES cycles.
        enter_code(16'h0000); tick(); tick();
        enter_code(16'h0000); tick();
        expect_out("t3_err2", 0, 1, 0, 0, 0, 2);
        tick();
        enter_code(16'h0000); tick();
        expect_out("t3_lock_start", 0, 1, 1, 0, 0, 3);
        for (int i = 1; i < 20; i++) begin
            if (i == 4) begin
                bus.key       = 4'h1;
                bus.key_valid = 1'b1;
            end
            if (i == 8) bus.clear = 1'b1;
            tick();
            bus.key_valid = 1'b0;
            bus.clear     = 1'b0;
            expect_out("t3_locked", 0, 0, 1, 0, 0, 3);
        end
        tick();
        expect_out("t3_lock_end", 0, 0, 0, 0, 0, 0);
        enter_code(16'h1A2B);
        tick();
        expect_out("t3_open", 1, 0, 0, 0, 0, 0);
        pulse_clear();

        // clear beats key_valid in the same cycle.
        key_in(4'h1); key_in(4'hA);
        expect_out("t5_two", 0, 0, 0, 0, 2, 0);
        bus.clear     = 1'b1;
        bus.key       = 4'h2;
        bus.key_valid = 1'b1;
        tick();
        bus.clear     = 1'b0;
        bus.key_valid = 1'b0;
        expect_out("t5_cleared", 0, 0, 0, 0, 0, 0);
        enter_code(16'h1A2B);
        tick();
        expect_out("t5_open", 1, 0, 0, 0, 0, 0);

        // Verify-mode keys in OPEN are ignored.
        key_in(4'h5);
        expect_out("t4_open_ignore", 1, 0, 0, 0, 0, 0);

        // Reprogram to 3344.
        bus.mode = 1'b0;
        key_in(4'h3);
        expect_out("t4_prog1", 0, 0, 0, 0, 1, 0);
        key_in(4'h3); key_in(4'h4); key_in(4'h4);
        expect_out("t4_prog_done", 0, 0, 0, 1, 0, 0);
        tick();
        expect_out("t4_pd_gone", 0, 0, 0, 0, 0, 0);
        bus.mode = 1'b1;
        enter_code(16'h1A2B);
        tick();
        expect_out("t4_old_err", 0, 1, 0, 0, 0, 1);
        tick();
        enter_code(16'h3344);
        tick();
        expect_out("t4_new_open", 1, 0, 0, 0, 0, 0);
        pulse_clear();

        // Reset in the middle of a lockout restores the default code.
        for (int i = 0; i < 3; i++) begin
            enter_code(16'h0000);
            tick();
            tick();
        end
        expect_out("rst_locked", 0, 0, 1, 0, 0, 3);
        repeat (4) tick();
        rst = 1'b0;
        #2;
        expect_out("rst_mid", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        enter_code(16'h1A2B);
        tick();
        expect_out("rst_default_pwd", 1, 0, 0, 0, 0, 0);
        pulse_clear();

        // Idle partial entry: discarded only with the timeout feature.
        enter_code(16'h0000);
        tick();
        expect_out("t6_fail1", 0, 1, 0, 0, 0, 1);
        tick();
        key_in(4'h1); key_in(4'hA);
        expect_out("t6_two", 0, 0, 0, 0, 2, 1);
        repeat (TIMEOUT - 1) tick();
        expect_out("t6_before", 0, 0, 0, 0, 2, 1);
        tick();
`ifdef ENTRY_TIMEOUT_EN
        expect_out("t6_timeout", 0, 0, 0, 0, 0, 1);
`else
        expect_out("t6_no_timeout", 0, 0, 0, 0, 2, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
